gpio_bank_ctrl: RTL and testbench

//  Three 8-bit bidirectional GPIO ports behind a shared 8-bit bidirectional host data bus.
//  The host reads and writes per-port data/direction registers through a 3-bit address with r_en/w_en strobes.

---
 rtl/gpio_bank_ctrl.sv | 99 +++++++++
 tb/tb_gpio_bank_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_ctrl.sv
// gpio_bank_ctrl: three WIDTH-bit tristate GPIO ports behind a shared host bus.
// Optional GPIO_INPUT_SYNC_EN: pin samples pass through a 2-flop synchronizer
// (pin-to-data latency 3 clk instead of 2 clk).

// gpio_pad: per-bit tristate pad, drives b when sel is set and always returns the pad level
module gpio_pad #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sel,
    input  logic [WIDTH-1:0] b,
    inout  wire  [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] c
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign pad[i] = sel[i] ? b[i] : 1'bz;
    end
    assign c = pad;
endmodule

module gpio_bank_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r_en,
    input  logic             w_en,
    input  logic [2:0]       add_reg,
    inout  wire  [WIDTH-1:0] data,
    inout  wire  [WIDTH-1:0] GPIO0,
    inout  wire  [WIDTH-1:0] GPIO1,
    inout  wire  [WIDTH-1:0] GPIO2
);
    logic [WIDTH-1:0] out_q [3];
    logic [WIDTH-1:0] dir_q [3];
    logic [WIDTH-1:0] in_q  [3];
    logic [WIDTH-1:0] pin   [3];
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] rd_src;
    logic [1:0]       port;
    logic             wr;

    assign port = add_reg[2:1];
    // a simultaneous read takes the bus, so the write is dropped
    assign wr = w_en && !r_en && (add_reg < 3'd6);
    assign rd_src = (add_reg >= 3'd6) ? '0 : add_reg[0] ? dir_q[port] : in_q[port];
    // bus released as soon as reset asserts, without waiting for a clock
    assign data = (r_en && reset) ? rdata : 'z;

    gpio_pad #(.WIDTH(WIDTH)) u_pad0 (.sel(dir_q[0]), .b(out_q[0]), .pad(GPIO0), .c(pin[0]));
    gpio_pad #(.WIDTH(WIDTH)) u_pad1 (.sel(dir_q[1]), .b(out_q[1]), .pad(GPIO1), .c(pin[1]));
    gpio_pad #(.WIDTH(WIDTH)) u_pad2 (.sel(dir_q[2]), .b(out_q[2]), .pad(GPIO2), .c(pin[2]));

`ifdef GPIO_INPUT_SYNC_EN
    logic [WIDTH-1:0] meta_q [3];

    // two-flop synchronizer in front of the input sample registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 3; n++) begin
                meta_q[n] <= '0;
                in_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                meta_q[n] <= pin[n];
                in_q[n]   <= meta_q[n];
            end
        end
    end
`else
    // single sample flop per pin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 3; n++) in_q[n] <= '0;
        end else begin
            for (int n = 0; n < 3; n++) in_q[n] <= pin[n];
        end
    end
`endif

    // host writes into the addressed output or direction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 3; n++) begin
                out_q[n] <= '0;
                dir_q[n] <= '0;
            end
        end else if (wr) begin
            if (add_reg[0]) dir_q[port] <= data;
            else out_q[port] <= data;
        end
    end

    // read data is refreshed every cycle the read strobe is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdata <= '0;
        else if (r_en) rdata <= rd_src;
    end
endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// tb_gpio_bank_ctrl: randomized self-checking bench for gpio_bank_ctrl against a register/pin model.
module tb_gpio_bank_ctrl;
    localparam int W = 8;
`ifdef GPIO_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset, r_en, w_en;
    logic [2:0] add_reg;
    wire [W-1:0] data, GPIO0, GPIO1, GPIO2;
    logic host_oe;
    logic [W-1:0] host_val;
    logic [2:0][W-1:0] ext_val, ext_oe, m_out, m_dir;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign data = host_oe ? host_val : 'z;
    for (genvar i = 0; i < W; i++) begin : g_ext
        assign GPIO0[i] = ext_oe[0][i] ? ext_val[0][i] : 1'bz;
        assign GPIO1[i] = ext_oe[1][i] ? ext_val[1][i] : 1'bz;
        assign GPIO2[i] = ext_oe[2][i] ? ext_val[2][i] : 1'bz;
    end

    gpio_bank_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .r_en(r_en), .w_en(w_en), .add_reg(add_reg),
        .data(data), .GPIO0(GPIO0), .GPIO1(GPIO1), .GPIO2(GPIO2)
    );

    function automatic logic [W-1:0] pin_model(input int n);
        return (m_dir[n] & m_out[n]) | (~m_dir[n] & ext_val[n]);
    endfunction

    function automatic logic [W-1:0] read_model(input logic [2:0] a);
        if (a >= 3'd6) return '0;
        return a[0] ? m_dir[a[2:1]] : pin_model(int'(a[2:1]));
    endfunction

    function automatic logic [W-1:0] pins(input int n);
        return (n == 0) ? GPIO0 : (n == 1) ? GPIO1 : GPIO2;
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [W-1:0] v);
        add_reg = a;
        host_val = v;
        host_oe = 1'b1;
        w_en = 1'b1;
        tick;
        w_en = 1'b0;
        host_oe = 1'b0;
        if (a < 3'd6) begin
            if (a[0]) m_dir[a[2:1]] = v;
            else m_out[a[2:1]] = v;
        end
        ext_oe = ~m_dir;
    endtask

    task automatic read_cycle(input logic [2:0] a);
        add_reg = a;
        r_en = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b0; r_en = 1'b0; w_en = 1'b0; add_reg = '0;
        host_oe = 1'b0; host_val = '0;
        m_out = '0; m_dir = '0;
        ext_val = 24'($urandom);
        ext_oe = '1;
        #100;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (pins(n) !== ext_val[n]) begin
                errors++;
                $display("FAIL reset_pin_release port=%0d got=%h exp=%h", n, pins(n), ext_val[n]);
            end
        end
        r_en = 1'b1; host_oe = 1'b1; host_val = 8'hFF; #1;
        checks++;
        if (data !== 8'hFF) begin
            errors++;
            $display("FAIL reset_bus_release got=%h exp=%h", data, 8'hFF);
        end
        r_en = 1'b0; host_oe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT) tick;
        for (int k = 0; k < 3; k++) begin
            read_cycle(3'(2 * k + 1));
            checks++;
            if (data !== 8'h00) begin
                errors++;
                $display("FAIL reset_dir_read addr=%0d got=%h exp=%h", 2 * k + 1, data, 8'h00);
            end
        end
        read_cycle(3'd0);
        checks++;
        if (data !== ext_val[0]) begin
            errors++;
            $display("FAIL reset_in_read got=%h exp=%h", data, ext_val[0]);
        end
        r_en = 1'b0;
    endtask

    task automatic test_input_read;
        logic [W-1:0] v;
        ext_val[0] = 8'hAF;
        repeat (LAT) tick;
        add_reg = 3'd0;
        r_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            checks++;
            if (data !== 8'hAF) begin
                errors++;
                $display("FAIL input_hold cycle=%0d got=%h exp=%h", k, data, 8'hAF);
            end
        end
        v = 8'($urandom_range(1, 254));
        if (v == 8'hAF) v = 8'h50;
        ext_val[0] = v;
        repeat (LAT - 1) tick;
        checks++;
        if (data !== 8'hAF) begin
            errors++;
            $display("FAIL input_latency_early got=%h exp=%h", data, 8'hAF);
        end
        tick;
        checks++;
        if (data !== v) begin
            errors++;
            $display("FAIL input_latency got=%h exp=%h", data, v);
        end
        r_en = 1'b0;
        host_oe = 1'b1; host_val = 8'h00; #1;
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL input_bus_release got=%h exp=%h", data, 8'h00);
        end
        host_oe = 1'b0;
    endtask

    task automatic test_output;
        host_write(3'd1, 8'hFF);
        host_write(3'd0, 8'h5A);
        checks++;
        if (GPIO0 !== 8'h5A) begin
            errors++;
            $display("FAIL output_pins got=%h exp=%h", GPIO0, 8'h5A);
        end
        repeat (LAT) tick;
        read_cycle(3'd0);
        checks++;
        if (data !== 8'h5A) begin
            errors++;
            $display("FAIL output_readback got=%h exp=%h", data, 8'h5A);
        end
        r_en = 1'b0;
    endtask

    task automatic test_mixed;
        ext_val[1] = 8'hCF;
        repeat (LAT) tick;
        read_cycle(3'd2);
        checks++;
        if (data !== 8'hCF) begin
            errors++;
            $display("FAIL mixed_input got=%h exp=%h", data, 8'hCF);
        end
        r_en = 1'b0;
        host_write(3'd3, 8'h0F);
        host_write(3'd2, 8'h03);
        checks++;
        if (GPIO1 !== 8'hC3) begin
            errors++;
            $display("FAIL mixed_pins got=%h exp=%h", GPIO1, 8'hC3);
        end
        repeat (LAT) tick;
        read_cycle(3'd2);
        checks++;
        if (data !== pin_model(1)) begin
            errors++;
            $display("FAIL mixed_read got=%h exp=%h", data, pin_model(1));
        end
        read_cycle(3'd3);
        checks++;
        if (data !== 8'h0F) begin
            errors++;
            $display("FAIL mixed_dir got=%h exp=%h", data, 8'h0F);
        end
        r_en = 1'b0;
    endtask

    task automatic test_collision;
        host_write(3'd5, 8'hFF);
        host_write(3'd4, 8'h3C);
        repeat (LAT) tick;
        read_cycle(3'd5);
        checks++;
        if (data !== 8'hFF) begin
            errors++;
            $display("FAIL collision_dir got=%h exp=%h", data, 8'hFF);
        end
        add_reg = 3'd4;
        w_en = 1'b1;
        tick;
        w_en = 1'b0;
        checks++;
        if (data !== 8'h3C) begin
            errors++;
            $display("FAIL collision_read got=%h exp=%h", data, 8'h3C);
        end
        checks++;
        if (GPIO2 !== 8'h3C) begin
            errors++;
            $display("FAIL collision_out_kept got=%h exp=%h", GPIO2, 8'h3C);
        end
        for (int a = 6; a < 8; a++) begin
            add_reg = 3'(a);
            tick;
            checks++;
            if (data !== 8'h00) begin
                errors++;
                $display("FAIL reserved_read addr=%0d got=%h exp=%h", a, data, 8'h00);
            end
        end
        r_en = 1'b0;
        host_write(3'd6, 8'hAA);
        host_write(3'd7, 8'h55);
        repeat (LAT) tick;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (pins(n) !== pin_model(n)) begin
                errors++;
                $display("FAIL reserved_write_pins port=%0d got=%h exp=%h", n, pins(n), pin_model(n));
            end
            read_cycle(3'(2 * n + 1));
            checks++;
            if (data !== m_dir[n]) begin
                errors++;
                $display("FAIL reserved_write_dir port=%0d got=%h exp=%h", n, data, m_dir[n]);
            end
            r_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid_read;
        host_write(3'd1, 8'hFF);
        host_write(3'd0, 8'hA5);
        repeat (LAT) tick;
        read_cycle(3'd0);
        checks++;
        if (data !== 8'hA5) begin
            errors++;
            $display("FAIL midreset_before got=%h exp=%h", data, 8'hA5);
        end
        #2;
        reset = 1'b0;
        m_out = '0; m_dir = '0;
        ext_val[0] = 8'h5A;
        ext_oe = '1;
        host_oe = 1'b1; host_val = 8'hFF;
        #1;
        checks++;
        if (data !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_bus got=%h exp=%h", data, 8'hFF);
        end
        checks++;
        if (GPIO0 !== 8'h5A) begin
            errors++;
            $display("FAIL midreset_pins got=%h exp=%h", GPIO0, 8'h5A);
        end
        host_oe = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (LAT) tick;
        read_cycle(3'd1);
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_dir got=%h exp=%h", data, 8'h00);
        end
        read_cycle(3'd0);
        checks++;
        if (data !== 8'h5A) begin
            errors++;
            $display("FAIL midreset_in got=%h exp=%h", data, 8'h5A);
        end
        r_en = 1'b0;
    endtask

    task automatic test_random;
        logic [2:0] a;
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 2))
                0: host_write(3'($urandom_range(0, 7)), 8'($urandom));
                1: ext_val[$urandom_range(0, 2)] = 8'($urandom);
                default: ext_val = 24'($urandom);
            endcase
            repeat (LAT) tick;
            for (int n = 0; n < 3; n++) begin
                checks++;
                if (pins(n) !== pin_model(n)) begin
                    errors++;
                    $display("FAIL random_pins it=%0d port=%0d got=%h exp=%h", it, n, pins(n), pin_model(n));
                end
            end
            a = 3'($urandom_range(0, 7));
            read_cycle(a);
            checks++;
            if (data !== read_model(a)) begin
                errors++;
                $display("FAIL random_read it=%0d addr=%0d got=%h exp=%h", it, a, data, read_model(a));
            end
            r_en = 1'b0;
            host_oe = 1'b1; host_val = 8'h00; #1;
            checks++;
            if (data !== 8'h00) begin
                errors++;
                $display("FAIL random_bus_release it=%0d got=%h exp=%h", it, data, 8'h00);
            end
            host_oe = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_input_read;
        test_output;
        test_mixed;
        test_collision;
        test_reset_mid_read;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
